sram_arbiter: RTL

Two-port arbiter and access sequencer for the off-chip 1M×16 asynchronous SRAM. Sits between the two on-chip masters (port 0: frame/sprite fetch; port 1: game-logic CPU) and the SRAM pins plus the registered tristate data buffer. It grants one request at a time round-robin, latches its command, and generates the active-low SRAM strobes and buffer enable with fixed cycle-level timing. Read data is returned on the granted port with a one-cycle valid pulse.

---
 rtl/sram_arbiter_pkg.sv | 27 ++
 rtl/sram_arbiter_rr_arb2.sv | 37 +++
 rtl/sram_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the two-port SRAM arbiter: sequencer states, latched
// command record and port index.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    typedef struct packed {
        logic        we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } cmd_t;

    typedef logic port_idx_t;

    localparam int unsigned WAIT_W = 4;

    function automatic logic [1:0] port_onehot(input port_idx_t idx);
        port_onehot = (idx == 1'b1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin selector; the last-grant register advances only when
// the sequencer actually accepts a request.
module rr_arb2
    import sram_arbiter_pkg::*;
(
    input  logic      Clk,
    input  logic      Reset,
    input  logic [1:0] req,
    input  logic      update,
    output port_idx_t grant
);

    port_idx_t last_r;

    // Lone requester wins; on a tie the port not served last wins.
    always_comb begin
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_r;
            default: grant = 1'b0;
        endcase
    end

    // Reset to "port 1 served last" so port 0 takes the first tie.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_r <= 1'b1;
        end else if (update) begin
            last_r <= grant;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin two-port access sequencer for the 1Mx16 asynchronous SRAM:
// fixed SETUP / ACCESS / RECOVER strobe timing with registered pin outputs.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [19:0] addr0,
    input  logic [19:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    input  logic [1:0]  be0,
    input  logic [1:0]  be1,
    output logic [1:0]  ack,
    output logic [1:0]  rvalid,
    output logic [15:0] rdata,
    output logic [19:0] ADDR,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [15:0] Data_to_SRAM,
    output logic        tristate_output_enable,
    input  logic [15:0] Data_from_SRAM
);

    localparam logic [WAIT_W-1:0] CNT_LOAD = WAIT_W'(ACCESS_CYCLES - 1);

    state_t             state_r;
    cmd_t               cmd_r;
    port_idx_t          win_r;
    logic [WAIT_W-1:0]  cnt_r;
    port_idx_t          grant_s;
    logic               accept_s;
    cmd_t               cmd_sel_s;

    rr_arb2 u_rr (
        .Clk    (Clk),
        .Reset  (Reset),
        .req    (req),
        .update (accept_s),
        .grant  (grant_s)
    );

    // Request acceptance and selection of the winning port's command.
    always_comb begin
        accept_s  = 1'b0;
        cmd_sel_s = '0;
        if ((state_r == IDLE) && (req != 2'b00)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (grant_s == 1'b1) begin
            cmd_sel_s = '{we: we[1], addr: addr1, wdata: wdata1, be: be1};
        end else begin
            cmd_sel_s = '{we: we[0], addr: addr0, wdata: wdata0, be: be0};
        end
    end

    // Address and write data come straight from the latched command, so they
    // hold their last value between accesses.
    assign ADDR         = cmd_r.addr;
    assign Data_to_SRAM = cmd_r.wdata;

    // Sequencer FSM with all strobes, handshakes and read data registered.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r                <= IDLE;
            cmd_r                  <= '0;
            win_r                  <= 1'b0;
            cnt_r                  <= '0;
            ack                    <= 2'b00;
            rvalid                 <= 2'b00;
            rdata                  <= 16'h0000;
            CE                     <= 1'b1;
            UB                     <= 1'b1;
            LB                     <= 1'b1;
            OE                     <= 1'b1;
            WE                     <= 1'b1;
            tristate_output_enable <= 1'b0;
        end else begin
            ack    <= 2'b00;
            rvalid <= 2'b00;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r                <= SETUP;
                        cmd_r                  <= cmd_sel_s;
                        win_r                  <= grant_s;
                        ack                    <= port_onehot(grant_s);
                        CE                     <= 1'b0;
                        tristate_output_enable <= cmd_sel_s.we;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    state_r <= ACCESS;
                    cnt_r   <= CNT_LOAD;
                    if (cmd_r.we) begin
                        WE <= 1'b0;
                        UB <= ~cmd_r.be[1];
                        LB <= ~cmd_r.be[0];
                    end else begin
                        OE <= 1'b0;
                        UB <= 1'b0;
                        LB <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt_r == {WAIT_W{1'b0}}) begin
                        state_r <= RECOVER;
                        WE      <= 1'b1;
                        OE      <= 1'b1;
                        UB      <= 1'b1;
                        LB      <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - {{(WAIT_W-1){1'b0}}, 1'b1};
                    end
                end
                RECOVER: begin
                    // Buffer keeps driving through RECOVER for write data hold.
                    state_r                <= IDLE;
                    CE                     <= 1'b1;
                    tristate_output_enable <= 1'b0;
                    if (!cmd_r.we) begin
                        rdata  <= Data_from_SRAM;
                        rvalid <= port_onehot(win_r);
                    end else begin
                        rdata <= rdata;
                    end
                end
                default: begin
                    state_r                <= IDLE;
                    CE                     <= 1'b1;
                    UB                     <= 1'b1;
                    LB                     <= 1'b1;
                    OE                     <= 1'b1;
                    WE                     <= 1'b1;
                    tristate_output_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule
